// File: rtl/mrc_datapath.sv
// Multi-register datapath: NREGS x WIDTH register file, shared bus, operand latch A,
// add/sub unit and result register G, sequenced by an IDLE/T1/T2/T3/DONE controller.
module mrc_datapath #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  localparam int SELW = $clog2(NREGS)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [SELW-1:0]  rx,
  input  logic [SELW-1:0]  ry,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] bus,
  output logic [2:0]       flags,
  input  logic [SELW-1:0]  rd_sel,
  output logic [WIDTH-1:0] rd_data
);

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_DONE} state_t;

  localparam logic [1:0] OP_MV  = 2'b00;
  localparam logic [1:0] OP_MVI = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b11;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [SELW-1:0]  rx_q, rx_d, ry_q, ry_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic [WIDTH-1:0] a_q, a_d, g_q, g_d;
  logic [2:0]       flags_q, flags_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];

  logic [WIDTH-1:0] bus_c;
  logic [WIDTH-1:0] opnd_c;
  logic [WIDTH:0]   alu_c;
  logic             wr_en_c;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    din_d   = din_q;
    a_d     = a_q;
    g_d     = g_q;
    flags_d = flags_q;
    bus_c   = '0;
    opnd_c  = '0;
    alu_c   = '0;
    wr_en_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          rx_d    = rx;
          ry_d    = ry;
          din_d   = din;
          state_d = S_T1;
        end
      end
      S_T1: begin
        case (op_q)
          OP_MV: begin
            bus_c   = regs_q[ry_q];
            wr_en_c = 1'b1;
            state_d = S_DONE;
          end
          OP_MVI: begin
            bus_c   = din_q;
            wr_en_c = 1'b1;
            state_d = S_DONE;
          end
          default: begin
            bus_c   = regs_q[rx_q];
            a_d     = bus_c;
            state_d = S_T2;
          end
        endcase
      end
      S_T2: begin
        // Subtract as A + ~bus + 1 so the carry-out directly means "no borrow".
        bus_c   = regs_q[ry_q];
        opnd_c  = (op_q == OP_SUB) ? ~bus_c : bus_c;
        alu_c   = {1'b0, a_q} + {1'b0, opnd_c} + {{WIDTH{1'b0}}, (op_q == OP_SUB)};
        g_d     = alu_c[WIDTH-1:0];
        flags_d = {alu_c[WIDTH],
                   (a_q[WIDTH-1] == opnd_c[WIDTH-1]) && (alu_c[WIDTH-1] != a_q[WIDTH-1]),
                   (alu_c[WIDTH-1:0] == '0)};
        state_d = S_T3;
      end
      S_T3: begin
        bus_c   = g_q;
        wr_en_c = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    for (int i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
    if (wr_en_c) regs_d[rx_q] = bus_c;

    busy_d = (state_d == S_T1) || (state_d == S_T2) || (state_d == S_T3);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
      din_q   <= '0;
      a_q     <= '0;
      g_q     <= '0;
      flags_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      din_q   <= din_d;
      a_q     <= a_d;
      g_q     <= g_d;
      flags_q <= flags_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bus     = bus_c;
  assign flags   = flags_q;
  assign rd_data = regs_q[rd_sel];

endmodule
